// File: rtl/tug_field.sv
// Tug-of-war field controller: ball position, edge scoring, per-player score,
// the between-round all-lit hold and match-over latch, all with registered outputs.
module tug_field #(
    parameter int NUM_LIGHTS  = 9,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4,
    localparam int SCORE_W    = $clog2(WIN_SCORE + 1),
    localparam int POS_W      = $clog2(NUM_LIGHTS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  l_press,
    input  logic                  r_press,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic [SCORE_W-1:0]    l_score,
    output logic [SCORE_W-1:0]    r_score,
    output logic                  point_l,
    output logic                  point_r,
    output logic                  match_over,
    output logic                  winner_l
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [POS_W-1:0]   POS_MAX   = POS_W'(NUM_LIGHTS - 1);
    localparam logic [POS_W-1:0]   POS_CTR   = POS_W'((NUM_LIGHTS - 1) / 2);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [NUM_LIGHTS-1:0] ONE    = NUM_LIGHTS'(1);

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        HOLD       = 2'd1,
        MATCH_OVER = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [POS_W-1:0]    pos, pos_n;
    logic [HOLD_W-1:0]   cnt, cnt_n;
    logic [SCORE_W-1:0]  l_score_n, r_score_n;
    logic [NUM_LIGHTS-1:0] lights_n;
    logic                point_l_n, point_r_n, match_over_n, winner_l_n;
    logic                mv_l, mv_r;

    // Simultaneous presses cancel out: a tie neither moves nor scores.
    assign mv_l = l_press & ~r_press;
    assign mv_r = r_press & ~l_press;

    always_comb begin
        state_n   = state;
        pos_n     = pos;
        cnt_n     = cnt;
        l_score_n = l_score;
        r_score_n = r_score;
        point_l_n = 1'b0;
        point_r_n = 1'b0;
        case (state)
            PLAY: begin
                if (mv_l) begin
                    if (pos == POS_MAX) begin
                        l_score_n = l_score + SCORE_W'(1);
                        point_l_n = 1'b1;
                        if (l_score_n == WIN) begin
                            state_n = MATCH_OVER;
                        end else begin
                            state_n = HOLD;
                            cnt_n   = HOLD_LOAD;
                        end
                    end else begin
                        pos_n = pos + POS_W'(1);
                    end
                end else if (mv_r) begin
                    if (pos == '0) begin
                        r_score_n = r_score + SCORE_W'(1);
                        point_r_n = 1'b1;
                        if (r_score_n == WIN) begin
                            state_n = MATCH_OVER;
                        end else begin
                            state_n = HOLD;
                            cnt_n   = HOLD_LOAD;
                        end
                    end else begin
                        pos_n = pos - POS_W'(1);
                    end
                end
            end
            HOLD: begin
                // The final decrement re-centres the ball so the centre light
                // appears right after the last all-lit cycle.
                if (cnt <= HOLD_W'(1)) begin
                    cnt_n   = '0;
                    pos_n   = POS_CTR;
                    state_n = PLAY;
                end else begin
                    cnt_n = cnt - HOLD_W'(1);
                end
            end
            MATCH_OVER: begin
                state_n = MATCH_OVER;
            end
            default: begin
                state_n = PLAY;
                pos_n   = POS_CTR;
                cnt_n   = '0;
            end
        endcase
        lights_n     = (state_n == PLAY) ? (ONE << pos_n) : '1;
        match_over_n = (state_n == MATCH_OVER);
        winner_l_n   = match_over_n && (l_score_n == WIN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= PLAY;
            pos        <= POS_CTR;
            cnt        <= '0;
            l_score    <= '0;
            r_score    <= '0;
            lights     <= ONE << POS_CTR;
            point_l    <= 1'b0;
            point_r    <= 1'b0;
            match_over <= 1'b0;
            winner_l   <= 1'b0;
        end else begin
            state      <= state_n;
            pos        <= pos_n;
            cnt        <= cnt_n;
            l_score    <= l_score_n;
            r_score    <= r_score_n;
            lights     <= lights_n;
            point_l    <= point_l_n;
            point_r    <= point_r_n;
            match_over <= match_over_n;
            winner_l   <= winner_l_n;
        end
    end

endmodule
